// File: rtl/tank_ctrl.sv
// Per-player tank/bullet game logic: stick/fire levels in, grid position,
// facing and a single bullet out, with a req/ack collision query before moves.
module tank_ctrl #(
  parameter int unsigned X_MAX       = 39,
  parameter int unsigned Y_MAX       = 29,
  parameter int unsigned INIT_X      = 32,
  parameter int unsigned INIT_Y      = 2,
  parameter int unsigned INIT_DIR    = 0,
  parameter int unsigned MOVE_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame,
  input  logic       i_enable,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_fire,
  output logic       o_req,
  output logic [5:0] o_req_x,
  output logic [5:0] o_req_y,
  input  logic       i_ack,
  input  logic       i_blocked,
  output logic [5:0] o_tank_x,
  output logic [5:0] o_tank_y,
  output logic [1:0] o_tank_dir,
  output logic       o_bullet_valid,
  output logic [5:0] o_bullet_x,
  output logic [5:0] o_bullet_y
);

  localparam int unsigned CW       = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_PERIOD - 1);
  localparam logic [5:0]    XM       = 6'(X_MAX);
  localparam logic [5:0]    YM       = 6'(Y_MAX);

  typedef enum logic {IDLE, QUERY} state_e;

  state_e        state_q, state_d;
  logic [5:0]    tank_x_q, tank_x_d, tank_y_q, tank_y_d;
  logic [1:0]    tank_dir_q, tank_dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic [5:0]    req_x_q, req_x_d, req_y_q, req_y_d;
  logic          bul_valid_q, bul_valid_d;
  logic [5:0]    bul_x_q, bul_x_d, bul_y_q, bul_y_d;
  logic [1:0]    bul_dir_q, bul_dir_d;
  logic          fire_q, fire_d;

  logic       held, fire_rise;
  logic [1:0] sel_dir;
  logic [12:0] tank_step, bul_step;

  // One-cell neighbour of (x,y) in direction d: {on_grid, nx, ny}
  function automatic logic [12:0] step(input logic [5:0] x, input logic [5:0] y,
                                       input logic [1:0] d);
    logic       ok;
    logic [5:0] nx, ny;
    ok = 1'b0;
    nx = x;
    ny = y;
    case (d)
      2'd0: begin ok = (y != 6'd0); ny = y - 6'd1; end
      2'd1: begin ok = (x < XM);    nx = x + 6'd1; end
      2'd2: begin ok = (y < YM);    ny = y + 6'd1; end
      default: begin ok = (x != 6'd0); nx = x - 6'd1; end
    endcase
    return {ok, nx, ny};
  endfunction

  // Stick priority decode: up > right > down > left
  always_comb begin
    held    = i_up | i_right | i_down | i_left;
    sel_dir = 2'd3;
    if (i_up)         sel_dir = 2'd0;
    else if (i_right) sel_dir = 2'd1;
    else if (i_down)  sel_dir = 2'd2;
  end

  // Next-state: tank movement FSM, fire edge detect and bullet motion
  always_comb begin
    state_d     = state_q;
    tank_x_d    = tank_x_q;
    tank_y_d    = tank_y_q;
    tank_dir_d  = tank_dir_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_x_d     = req_x_q;
    req_y_d     = req_y_q;
    bul_valid_d = bul_valid_q;
    bul_x_d     = bul_x_q;
    bul_y_d     = bul_y_q;
    bul_dir_d   = bul_dir_q;
    fire_d      = i_fire;
    fire_rise   = i_fire & ~fire_q;
    tank_step   = step(tank_x_q, tank_y_q, sel_dir);
    bul_step    = step(bul_x_q, bul_y_q, bul_dir_q);

    case (state_q)
      IDLE: begin
        if (i_enable && i_frame) begin
          if (held) begin
            tank_dir_d = sel_dir;
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              if (tank_step[12]) begin
                state_d = QUERY;
                req_d   = 1'b1;
                req_x_d = tank_step[11:6];
                req_y_d = tank_step[5:0];
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      QUERY: begin
        // An in-flight query completes even while disabled
        if (i_ack) begin
          if (!i_blocked) begin
            tank_x_d = req_x_q;
            tank_y_d = req_y_q;
          end
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Spawn takes precedence over motion, so a fresh bullet never moves on its first tick
    if (i_enable) begin
      if (fire_rise && !bul_valid_q) begin
        bul_valid_d = 1'b1;
        bul_x_d     = tank_x_q;
        bul_y_d     = tank_y_q;
        bul_dir_d   = tank_dir_q;
      end else if (i_frame && bul_valid_q) begin
        if (bul_step[12]) begin
          bul_x_d = bul_step[11:6];
          bul_y_d = bul_step[5:0];
        end else begin
          bul_valid_d = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tank_x_q    <= 6'(INIT_X);
      tank_y_q    <= 6'(INIT_Y);
      tank_dir_q  <= 2'(INIT_DIR);
      cnt_q       <= '0;
      req_q       <= 1'b0;
      req_x_q     <= 6'd0;
      req_y_q     <= 6'd0;
      bul_valid_q <= 1'b0;
      bul_x_q     <= 6'd0;
      bul_y_q     <= 6'd0;
      bul_dir_q   <= 2'd0;
      fire_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tank_x_q    <= tank_x_d;
      tank_y_q    <= tank_y_d;
      tank_dir_q  <= tank_dir_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_x_q     <= req_x_d;
      req_y_q     <= req_y_d;
      bul_valid_q <= bul_valid_d;
      bul_x_q     <= bul_x_d;
      bul_y_q     <= bul_y_d;
      bul_dir_q   <= bul_dir_d;
      fire_q      <= fire_d;
    end
  end

  assign o_req          = req_q;
  assign o_req_x        = req_x_q;
  assign o_req_y        = req_y_q;
  assign o_tank_x       = tank_x_q;
  assign o_tank_y       = tank_y_q;
  assign o_tank_dir     = tank_dir_q;
  assign o_bullet_valid = bul_valid_q;
  assign o_bullet_x     = bul_x_q;
  assign o_bullet_y     = bul_y_q;

endmodule

// File: tb/tb_tank_ctrl.sv
// Bench for tank_ctrl: directed scenarios plus random stimulus against a cycle model.
module tb_tank_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, i_frame, i_enable, i_up, i_down, i_left, i_right, i_fire;
  logic       i_ack, i_blocked;
  logic       o_req, o_bullet_valid;
  logic [5:0] o_req_x, o_req_y, o_tank_x, o_tank_y, o_bullet_x, o_bullet_y;
  logic [1:0] o_tank_dir;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tank_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_frame(i_frame), .i_enable(i_enable),
    .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right), .i_fire(i_fire),
    .o_req(o_req), .o_req_x(o_req_x), .o_req_y(o_req_y),
    .i_ack(i_ack), .i_blocked(i_blocked),
    .o_tank_x(o_tank_x), .o_tank_y(o_tank_y), .o_tank_dir(o_tank_dir),
    .o_bullet_valid(o_bullet_valid), .o_bullet_x(o_bullet_x), .o_bullet_y(o_bullet_y)
  );

  // Reference state: plain integers, one record of what the game should show
  int m_tx, m_ty, m_dir, m_ticks, m_rx, m_ry, m_bx, m_by, m_bd;
  bit m_busy, m_bv, m_fprev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dxf(input int d);
    return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
  endfunction

  function automatic int dyf(input int d);
    return (d == 0) ? -1 : ((d == 2) ? 1 : 0);
  endfunction

  function automatic bit on_grid(input int x, input int y);
    return x >= 0 && x <= 39 && y >= 0 && y <= 29;
  endfunction

  // Advance the reference by one clock using the currently driven inputs
  task automatic model_step();
    int  sel, nx, ny;
    bit  rise, any;
    if (!rst_n) begin
      m_tx = 32; m_ty = 2; m_dir = 0; m_ticks = 0; m_busy = 0; m_rx = 0; m_ry = 0;
      m_bv = 0; m_bx = 0; m_by = 0; m_bd = 0; m_fprev = 0;
      return;
    end
    rise = i_fire && !m_fprev;
    m_fprev = i_fire;
    // bullet first: it sees the tank as it was before this edge
    if (i_enable) begin
      if (rise && !m_bv) begin
        m_bv = 1; m_bx = m_tx; m_by = m_ty; m_bd = m_dir;
      end else if (i_frame && m_bv) begin
        nx = m_bx + dxf(m_bd);
        ny = m_by + dyf(m_bd);
        if (on_grid(nx, ny)) begin m_bx = nx; m_by = ny; end
        else m_bv = 0;
      end
    end
    any = i_up || i_right || i_down || i_left;
    sel = i_up ? 0 : (i_right ? 1 : (i_down ? 2 : 3));
    if (m_busy) begin
      if (i_ack) begin
        if (!i_blocked) begin m_tx = m_rx; m_ty = m_ry; end
        m_busy = 0;
      end
    end else if (i_enable && i_frame) begin
      if (!any) m_ticks = 0;
      else begin
        m_dir = sel;
        m_ticks = m_ticks + 1;
        if (m_ticks == 4) begin
          m_ticks = 0;
          nx = m_tx + dxf(sel);
          ny = m_ty + dyf(sel);
          if (on_grid(nx, ny)) begin m_busy = 1; m_rx = nx; m_ry = ny; end
        end
      end
    end
  endtask

  // Apply one cycle of inputs, step the model, then compare after the edge
  task automatic cyc(input bit fr, input bit en, input bit u, input bit d, input bit l,
                     input bit r, input bit f, input bit ak, input bit bl, input bit rs);
    rst_n = rs; i_frame = fr; i_enable = en; i_up = u; i_down = d; i_left = l;
    i_right = r; i_fire = f; i_ack = ak; i_blocked = bl;
    model_step();
    @(posedge clk);
    #1;
    chk("tank", {o_tank_x, o_tank_y, o_tank_dir}, {6'(m_tx), 6'(m_ty), 2'(m_dir)});
    chk("req", {o_req, o_req_x, o_req_y}, {m_busy, 6'(m_rx), 6'(m_ry)});
    chk("bullet", {o_bullet_valid, o_bullet_x, o_bullet_y}, {m_bv, 6'(m_bx), 6'(m_by)});
  endtask

  task automatic idle_cyc();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic tick(input bit u, input bit d, input bit l, input bit r);
    cyc(1, 1, u, d, l, r, 0, 0, 0, 1);
    cyc(0, 1, u, d, l, r, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit fl;
    do_reset();
    chk("rst_tank", {o_tank_x, o_tank_y, o_tank_dir}, {6'd32, 6'd2, 2'd0});
    chk("rst_req", {o_req, o_bullet_valid}, 2'b00);

    // move right one cell with an immediate unblocked ack
    for (int k = 1; k <= 4; k++) begin
      tick(0, 0, 0, 1);
      if (k == 1) chk("turn_dir", o_tank_dir, 2'd1);
    end
    chk("req_tgt", {o_req, o_req_x, o_req_y}, {1'b1, 6'd33, 6'd2});
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
    chk("move_x", o_tank_x, 6'd33);
    chk("req_drop", o_req, 1'b0);

    // walk to the right edge, then a further attempt must not query
    for (int m = 0; m < 6; m++) begin
      for (int k = 0; k < 4; k++) tick(0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
    end
    chk("edge_x", o_tank_x, 6'd39);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 1);
    chk("edge_noreq", {o_req, o_tank_x, o_tank_y}, {1'b0, 6'd39, 6'd2});

    // up+left resolves to up; blocked after a long wait
    do_reset();
    for (int k = 0; k < 4; k++) tick(1, 0, 1, 0);
    chk("prio_dir", o_tank_dir, 2'd0);
    for (int w = 0; w < 5; w++) begin
      idle_cyc();
      chk("req_hold", {o_req, o_req_x, o_req_y}, {1'b1, 6'd32, 6'd1});
    end
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("blocked_pos", {o_req, o_tank_x, o_tank_y}, {1'b0, 6'd32, 6'd2});

    // bullet fired upward runs off the top; second edge ignored
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    chk("spawn", {o_bullet_valid, o_bullet_x, o_bullet_y}, {1'b1, 6'd32, 6'd2});
    idle_cyc();
    tick(0, 0, 0, 0);
    chk("bul_1", {o_bullet_valid, o_bullet_x, o_bullet_y}, {1'b1, 6'd32, 6'd1});
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    idle_cyc();
    tick(0, 0, 0, 0);
    chk("bul_0", {o_bullet_valid, o_bullet_x, o_bullet_y}, {1'b1, 6'd32, 6'd0});
    tick(0, 0, 0, 0);
    chk("bul_off", {o_bullet_valid, o_bullet_x, o_bullet_y}, {1'b0, 6'd32, 6'd0});
    idle_cyc();
    chk("no_queue", o_bullet_valid, 1'b0);

    // fire edge on a frame tick spawns without advancing
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    chk("spawn_frame", {o_bullet_valid, o_bullet_x, o_bullet_y}, {1'b1, 6'd32, 6'd2});
    idle_cyc();

    // reset while a query is outstanding
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 1);
    chk("pre_rst_req", o_req, 1'b1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid", {o_req, o_bullet_valid, o_tank_x, o_tank_y, o_tank_dir},
        {2'b00, 6'd32, 6'd2, 2'd0});
    idle_cyc();

    // random play
    fl = 0;
    for (int c = 0; c < 4000; c++) begin
      bit fr, en, u, d, l, r, ak, bl, rs;
      fr = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 9) != 0);
      u  = ($urandom_range(0, 4) == 0);
      d  = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) fl = ~fl;
      ak = m_busy && ($urandom_range(0, 2) == 0);
      bl = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 599) != 0);
      cyc(fr, en, u, d, l, r, fl, ak, bl, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tank_ctrl.md
Name: tank_ctrl

Overview:
- Per-player game-logic stage between the joystick/debounce front end and the VGA renderer.
- Turns debounced stick and fire levels into tank grid position, facing and a single bullet, and updates them on frame ticks.
- Before each tank move it asks the map/collision block whether the target cell is blocked, using a req/ack handshake.
- Outputs drive the VGA tank/bullet inputs directly.

Parameters:
X_MAX, 39, largest legal x cell (40 cells of 16 px); x range 0..X_MAX, 6-bit
Y_MAX, 29, largest legal y cell; y range 0..Y_MAX, 6-bit
INIT_X, 32, tank x after reset
INIT_Y, 2, tank y after reset
INIT_DIR, 0, tank facing after reset
MOVE_PERIOD, 4, frame ticks per tank step while a direction is held (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
i_frame  input  1  one-cycle pulse per video frame (start of vblank)
i_enable  input  1  game running; low freezes all state
i_up  input  1  debounced stick up, active-high level
i_down  input  1  debounced stick down, active-high level
i_left  input  1  debounced stick left, active-high level
i_right  input  1  debounced stick right, active-high level
i_fire  input  1  debounced fire, active-high level
o_req  output  1  collision query valid
o_req_x  output  6  queried cell x
o_req_y  output  6  queried cell y
i_ack  input  1  query answered this cycle
i_blocked  input  1  target cell blocked; valid when i_ack=1
o_tank_x  output  6  tank cell x
o_tank_y  output  6  tank cell y
o_tank_dir  output  2  facing: 0 up, 1 right, 2 down, 3 left
o_bullet_valid  output  1  bullet on screen
o_bullet_x  output  6  bullet cell x
o_bullet_y  output  6  bullet cell y

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-low `rst_n`.
- Reset values: tank = (INIT_X, INIT_Y, INIT_DIR); o_req=0; o_req_x/y=0; o_bullet_valid=0; bullet x/y=0; move counter=0; FSM=IDLE; fire history=0.
- Reset mid-query: o_req is low the cycle after reset is sampled. The collision block must tolerate a dropped request.
- Direction select: priority up > right > down > left. "Held" means any of the four is high.
- FSM IDLE, on an i_frame cycle with i_enable=1 and a direction held:
  - o_tank_dir takes the selected direction on the next edge (turning needs no query).
  - move counter increments.
  - When the counter equals MOVE_PERIOD-1 it clears and a move is attempted.
- Move attempt: target = tank position plus one cell in the selected direction.
  - Target outside 0..X_MAX / 0..Y_MAX: no query, position unchanged, stay in IDLE.
  - Otherwise go to QUERY: o_req=1 next cycle, with o_req_x/y = target, held stable until ack.
- IDLE with no direction held on a frame tick: move counter clears to 0.
- FSM QUERY:
  - The cycle with o_req=1 and i_ack=1 completes the handshake.
  - If i_blocked=0, o_tank_x/y take the target on the next edge; if blocked, position is unchanged.
  - Next cycle: o_req=0, FSM=IDLE. Earliest response is the cycle after o_req rises; ack latency is unbounded.
  - Frame ticks during QUERY do not advance the move counter or facing; bullet processing continues.
- i_enable=0: no new query, no position/dir/bullet change, counter held.
  - An in-flight query still completes its handshake and applies the result, then freezes.
- Fire: rising edge of i_fire (registered history, updated every cycle including when disabled).
  - With i_enable=1 and o_bullet_valid=0: next cycle o_bullet_valid=1, bullet position = current tank x/y, bullet direction = current o_tank_dir (internal 2-bit register).
  - Edges while a bullet is active are discarded, not queued.
- Bullet motion: on each i_frame with i_enable=1 and bullet valid, the bullet advances one cell in its direction.
  - If the next cell is off-grid, o_bullet_valid clears and x/y keep their last value.
- Simultaneous fire edge and i_frame with no bullet: the bullet spawns and does not move on that tick.
- Simultaneous tank move and bullet spawn: the bullet spawns at the pre-move tank position.
- Bullet and tank update independently on the same tick.

Test Plan:
- Reset, then hold i_right, pulse i_frame x4, ack with blocked=0 one cycle after req -> dir=1 after 1st tick; req at (33,2) after 4th tick; o_tank_x=33 after ack; o_req low next cycle.
- Tank at (39,2), hold right, 4 frame ticks -> o_req stays 0, tank remains (39,2).
- Hold up and left together, 4 ticks, ack blocked=1 after 5-cycle wait -> dir=0; o_req_x/y=(32,1) stable for all 5 cycles; position stays (32,2).
- Tank (32,2) dir=0, pulse i_fire, then 3 frame ticks -> bullet valid at (32,2), then (32,1), (32,0), then valid=0 on 3rd tick; second fire edge while the bullet is active is ignored.
- Fire edge coincident with i_frame -> bullet appears at the tank cell without advancing that tick.
- Deassert rst_n while o_req=1 -> next cycle o_req=0, tank (32,2,0), bullet invalid.
